// File: rtl/spi_frame_sender.sv
// spi_frame_sender: SPI mode-0 master that streams one row-major frame, MSB first, per start request.
// Define SPI_FRAME_SENDER_HEADER_EN to prefix each frame with the `cmd` header byte.
module spi_frame_sender #(
    parameter int unsigned rows    = 8,
    parameter int unsigned columns = 32,
    parameter int unsigned width   = 24,
    parameter int unsigned clkdiv  = 2,
    parameter logic [7:0]  cmd     = 8'h01
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(rows)-1:0]    rrow,
    output logic [$clog2(columns)-1:0] rcol,
    input  logic [width-1:0]           rdata,
    output logic                       sclk,
    output logic                       ss,
    output logic                       mosi
);

    localparam int unsigned RW = $clog2(rows);
    localparam int unsigned CW = $clog2(columns);
    localparam int unsigned DW = $clog2(clkdiv + 1);
    localparam int unsigned BW = $clog2(width + 9);
    localparam int unsigned PW = $clog2(rows * columns + 1);

    localparam logic [RW-1:0] LAST_ROW = RW'(rows - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(columns - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(clkdiv - 1);
    localparam logic [PW-1:0] NPIX     = PW'(rows * columns);

`ifdef SPI_FRAME_SENDER_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, TAIL, HEADER} state_t;

    state_t           state, state_d;
    logic [width-1:0] sreg, sreg_d;
    logic [DW-1:0]    div_cnt, div_d;
    logic [BW-1:0]    bit_cnt, bit_d, unit_last;
    logic [PW-1:0]    pix_cnt, pix_d;
    logic             hdr, hdr_d;
    logic             sclk_d, ss_d, busy_d, done_d;
    logic [RW-1:0]    rrow_d, nxt_row;
    logic [CW-1:0]    rcol_d, nxt_col;

    // Shifting on every falling edge leaves sreg cleared after the last bit, so mosi idles low.
    assign mosi      = sreg[width-1];
    assign unit_last = hdr ? BW'(7) : BW'(width - 1);

    always_comb begin
        nxt_row = rrow;
        nxt_col = rcol + 1'b1;
        if (rcol == LAST_COL) begin
            nxt_col = '0;
            nxt_row = (rrow == LAST_ROW) ? '0 : rrow + 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        sreg_d  = sreg;
        sclk_d  = sclk;
        ss_d    = ss;
        busy_d  = busy;
        done_d  = 1'b0;
        rrow_d  = rrow;
        rcol_d  = rcol;
        div_d   = div_cnt;
        bit_d   = bit_cnt;
        pix_d   = pix_cnt;
        hdr_d   = hdr;
        case (state)
            IDLE: begin
                ss_d   = 1'b1;
                sclk_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    state_d = HDR_EN ? HEADER : FETCH;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    rrow_d  = '0;
                    rcol_d  = '0;
                    div_d   = '0;
                    bit_d   = '0;
                    pix_d   = '0;
                end
            end
            HEADER: begin
                sreg_d                = '0;
                sreg_d[width-1 -: 8]  = cmd;
                hdr_d                 = 1'b1;
                state_d               = SHIFT;
            end
            FETCH: begin
                sreg_d  = rdata;
                rrow_d  = nxt_row;
                rcol_d  = nxt_col;
                pix_d   = pix_cnt + 1'b1;
                hdr_d   = 1'b0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk;
                    if (sclk) begin
                        sreg_d = sreg << 1;
                        bit_d  = bit_cnt + 1'b1;
                        if (bit_cnt == unit_last) begin
                            bit_d = '0;
                            if (pix_cnt == NPIX) begin
                                state_d = TAIL;
                            end else begin
                                // Next pixel was prefetched during this one; reload without an sclk gap.
                                sreg_d = rdata;
                                rrow_d = nxt_row;
                                rcol_d = nxt_col;
                                pix_d  = pix_cnt + 1'b1;
                                hdr_d  = 1'b0;
                            end
                        end
                    end
                end else begin
                    div_d = div_cnt + 1'b1;
                end
            end
            TAIL: begin
                sclk_d = 1'b0;
                if (div_cnt == DIV_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                    ss_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '0;
            sclk    <= 1'b0;
            ss      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rrow    <= '0;
            rcol    <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            pix_cnt <= '0;
            hdr     <= 1'b0;
        end else begin
            state   <= state_d;
            sreg    <= sreg_d;
            sclk    <= sclk_d;
            ss      <= ss_d;
            busy    <= busy_d;
            done    <= done_d;
            rrow    <= rrow_d;
            rcol    <= rcol_d;
            div_cnt <= div_d;
            bit_cnt <= bit_d;
            pix_cnt <= pix_d;
            hdr     <= hdr_d;
        end
    end

endmodule

// File: tb/tb_spi_frame_sender.sv
// tb_spi_frame_sender: random frames checked against a bit-stream model built from the frame buffer.
// Honours SPI_FRAME_SENDER_HEADER_EN for the expected header byte.
module tb_spi_frame_sender;

    localparam int unsigned ROWS = 3;
    localparam int unsigned COLS = 5;
    localparam int unsigned W    = 24;
    localparam int unsigned CD   = 3;
    localparam logic [7:0]  CMD  = 8'hB4;
`ifdef SPI_FRAME_SENDER_HEADER_EN
    localparam int HB = 8;
`else
    localparam int HB = 0;
`endif
    localparam int NB       = ROWS * COLS * W + HB;
    localparam int DONE_CYC = 2 + 2 * CD * NB + CD;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         busy, done, sclk, ss, mosi;
    logic [1:0]   rrow;
    logic [2:0]   rcol;
    logic [W-1:0] rdata;
    logic [W-1:0] mem [ROWS*COLS];

    int checks = 0;
    int errors = 0;

    int   cyc, rises, hi_len, lo_len, phase_bad, mosi_bad, dones, done_cyc, first_rise;
    bit   seen_fall;
    logic sclk_q, mosi_q;
    bit   cap[$];
    bit   exp_q[$];

    spi_frame_sender #(
        .rows(ROWS), .columns(COLS), .width(W), .clkdiv(CD), .cmd(CMD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rrow(rrow), .rcol(rcol), .rdata(rdata),
        .sclk(sclk), .ss(ss), .mosi(mosi)
    );

    always #5 clk = ~clk;

    // Synchronous-read frame buffer, one cycle of latency.
    always @(posedge clk) rdata <= mem[int'(rrow) * COLS + int'(rcol)];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic mon_clear();
        cap.delete();
        rises = 0; hi_len = 0; lo_len = 0; phase_bad = 0; mosi_bad = 0;
        dones = 0; done_cyc = -1; first_rise = -1; seen_fall = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (sclk === 1'b1 && sclk_q === 1'b0) begin
            if (!ss) cap.push_back(mosi);
            rises++;
            if (mosi !== mosi_q) mosi_bad++;
            if (seen_fall && lo_len != int'(CD)) phase_bad++;
            if (first_rise < 0) first_rise = cyc;
            hi_len = 1;
        end else if (sclk === 1'b0 && sclk_q === 1'b1) begin
            if (hi_len != int'(CD)) phase_bad++;
            seen_fall = 1'b1;
            lo_len = 1;
        end else if (sclk === 1'b1) begin
            hi_len++;
        end else begin
            lo_len++;
        end
        if (done === 1'b1) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        sclk_q = sclk;
        mosi_q = mosi;
    endtask

    task automatic fill(input bit directed);
        for (int i = 0; i < ROWS * COLS; i++) mem[i] = W'($urandom);
        if (directed) begin
            mem[0] = 24'hA5A5A5; mem[1] = 24'h000001;
            mem[2] = 24'h800000; mem[3] = 24'hFFFFFF;
        end
    endtask

    task automatic build_exp();
        logic [7:0] c;
        logic [W-1:0] px;
        c = CMD;
        exp_q.delete();
        for (int i = HB - 1; i >= 0; i--) exp_q.push_back(c[i]);
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++) begin
                px = mem[r * COLS + k];
                for (int b = W - 1; b >= 0; b--) exp_q.push_back(px[b]);
            end
    endtask

    task automatic run_frame(input int extra_at, input bit hold);
        int bad;
        build_exp();
        mon_clear();
        start = 1'b1;
        cyc = 0;
        tick();
        check("c1_ss", ss, 0);
        check("c1_busy", busy, 1);
        check("c1_addr", {rrow, rcol}, 0);
        if (!hold) start = 1'b0;
        tick();
        check("c2_mosi", mosi, exp_q[0]);
        while (dones == 0 && cyc < DONE_CYC + 20) begin
            start = hold || (cyc == extra_at);
            tick();
        end
        check("done_seen", dones, 1);
        check("done_cyc", done_cyc, DONE_CYC);
        check("done_ss", ss, 1);
        check("done_busy", busy, 0);
        check("done_addr", {rrow, rcol}, 0);
        check("first_rise", first_rise, 2 + CD);
        check("bits", cap.size(), NB);
        check("rises", rises, NB);
        bad = 0;
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            if (cap[i] != exp_q[i]) bad++;
        check("bit_errs", bad, 0);
        check("sclk_phase", phase_bad, 0);
        check("mosi_hold", mosi_bad, 0);
        if (!hold) begin
            start = 1'b0;
            repeat (2 * CD + 4) tick();
            check("one_done", dones, 1);
            check("idle_ss", ss, 1);
            check("idle_sclk", sclk, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < ROWS * COLS; i++) mem[i] = '0;
        sclk_q = 1'b0;
        mosi_q = 1'b0;
        cyc = 0;
        mon_clear();

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        mon_clear();
        repeat (10) tick();
        check("rst_ss", ss, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", dones, 0);
        check("rst_addr", {rrow, rcol}, 0);

        fill(1'b1);
        run_frame(-1, 1'b0);

        fill(1'b0);
        run_frame(DONE_CYC / 2, 1'b0);

        // start held high: next frame begins the cycle after done, then is reset mid-stream
        fill(1'b0);
        run_frame(-1, 1'b1);
        tick();
        check("b2b_ss", ss, 0);
        check("b2b_busy", busy, 1);
        start = 1'b0;
        mon_clear();
        while (rises < 200 && cyc < 4 * DONE_CYC) tick();
        check("rst_point", rises, 200);
        rst = 1'b1;
        tick();
        check("mid_rst_ss", ss, 1);
        check("mid_rst_sclk", sclk, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", {rrow, rcol}, 0);
        rst = 1'b0;
        repeat (4) tick();

        repeat (3) begin
            fill(1'b0);
            run_frame(-1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_sender.md
# spi_frame_sender

SPI master that streams one full display frame from a local pixel frame buffer to the display controller's SPI loader. It is the transmit end of the panel's SPI link. A host-side FPGA or a test harness uses it to push frames to the panel. It reads pixels in row-major order through a synchronous read port and serialises each pixel as 24 bits, MSB first, in SPI mode 0. One frame is sent per `start` request.

## Interface

Parameters:
- `rows`, default 8: panel rows per frame.
- `columns`, default 32: panel columns per frame.
- `width`, default 24: bits per pixel.
- `clkdiv`, default 2: `sclk` half-period in `clk` cycles; must be ≥1.
- `cmd`, default 8'h01: header byte, used only with `SPI_FRAME_SENDER_HEADER_EN`.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst`, in, 1: reset. Synchronous, active-high.
- `start`, in, 1: frame request. Sampled only while idle.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`.
- `done`, out, 1: one-cycle pulse when the frame is complete.
- `rrow`, out, $clog2(rows): frame buffer read row.
- `rcol`, out, $clog2(columns): frame buffer read column.
- `rdata`, in, `width`: pixel data, valid one cycle after `rrow`/`rcol`.
- `sclk`, out, 1: SPI clock. Idles low.
- `ss`, out, 1: slave select. Active low, idles high.
- `mosi`, out, 1: serial data.

## Operation

FSM states: IDLE, FETCH, SHIFT, TAIL.

- **IDLE**
  - `ss`=1, `sclk`=0, `busy`=0.
  - On `start`=1: go to FETCH, drive `ss`=0, `busy`=1, `rrow`=0, `rcol`=0.
- **FETCH** (one cycle)
  - Load the shift register from `rdata`; `mosi` = bit `width-1`.
  - Advance the read address to the next pixel.
  - Go to SHIFT.
- **SHIFT**
  - A half-period counter toggles `sclk` every `clkdiv` cycles. Rising edge first.
  - On each falling edge, shift left and present the next bit on `mosi`.
  - After the falling edge that ends bit 0 of a pixel:
    - If more pixels remain, load the prefetched `rdata` and advance the address. No `sclk` gap between pixels.
    - If it was the last pixel, go to TAIL.
- **TAIL**
  - Hold `sclk`=0 for `clkdiv` cycles.
  - Then drive `ss`=1, `busy`=0, pulse `done`, and return to IDLE.
- **Pixel order:** `(row, col)` = (0,0), (0,1) … (0,columns-1), (1,0) … (rows-1, columns-1).
- **Address wrap:**
  - `rcol` wraps to 0 and `rrow` increments when `rcol` = columns-1.
  - After the last pixel, the address returns to (0,0).
- **Frame length:** B = rows·columns·width bits (+8 with header).
- **Boundary conditions:**
  - `start` while busy: ignored; it is not queued.
  - `start` held high continuously: a new frame starts on the cycle after `done`, i.e. back-to-back frames with at least one idle cycle with `ss`=1.
  - `rst` asserted mid-frame: on the next edge `ss`=1, `sclk`=0, state IDLE. The partial frame is abandoned; the receiver discards it when `ss` deasserts.
- **Reset values:** `ss`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rrow`=0, `rcol`=0.

## Timing

Let `start` be sampled at cycle 0.

- Cycle 1: `ss`=0, `busy`=1, address (0,0) presented.
- Cycle 2: `mosi` = pixel(0,0)[width-1].
- First `sclk` rising edge at cycle 2+`clkdiv`; first falling edge at 2+2·`clkdiv`.
- Each bit spans 2·`clkdiv` cycles. `mosi` changes only on `sclk` falling edges, or at cycle 2.
- The receiver samples on the rising edge, so `mosi` has `clkdiv` cycles of setup and of hold.
- Last falling edge at cycle 2+2·`clkdiv`·B.
- At cycle 2+2·`clkdiv`·B+`clkdiv`: `ss`=1, `busy`=0, `done`=1.
- Read port: the address is stable for at least 2·`clkdiv`·width cycles per pixel. The memory needs only single-cycle read latency.

## Configuration

- `SPI_FRAME_SENDER_HEADER_EN` defined:
  - The FETCH state is preceded by one byte `cmd`, MSB first, under the same `ss` assertion.
  - The first pixel address is presented during the last header bit.
  - B grows by 8.
- Not defined: the frame starts directly with pixel(0,0), and B = rows·columns·width.

## Test plan

- **Reset idle:** `rst`=1 for 3 cycles, then idle 10 cycles → `ss`=1, `sclk`=0, `mosi`=0, `busy`=0, `done` never pulses.
- **Small frame, header off:** rows=2, columns=2, `clkdiv`=1, pixels 0xA5A5A5, 0x000001, 0x800000, 0xFFFFFF; `start` at cycle 0 → a bench slave sampling on rising edges captures the 96 bits in order; `done` at cycle 195; exactly 96 rising `sclk` edges.
- **Divider:** `clkdiv`=3, default size → `sclk` high and low phases are each exactly 3 cycles; `mosi` is stable across every rising edge; `done` at cycle 2+6·6144+3 = 36869.
- **Start while busy:** pulse `start` again mid-frame → ignored; a single `done`; the frame is uncorrupted.
- **Reset mid-frame:** assert `rst` at bit 1000 → `ss`=1 and `sclk`=0 on the next cycle; a new `start` afterwards sends a full correct frame from (0,0).
- **Header:** with `SPI_FRAME_SENDER_HEADER_EN`, `cmd`=8'h01, 2×2 frame → the first 8 bits captured are 0x01, then the pixel stream; `done` at cycle 2+2·104+1 = 211.
